// File: rtl/llc_chan_sched_if.sv
// Bundle between the LLC input buffers / datapath and the channel scheduler.
// Handshake: a channel holds ch_valid and its ch_set slice stable until it sees its ch_ready bit; the transfer happens on a clock edge where both are high.
interface llc_chan_sched_if #(
  parameter int NUM_CH   = 4,
  parameter int SET_BITS = 9
);
  localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]          ch_valid;
  logic [NUM_CH*SET_BITS-1:0] ch_set;
  logic [NUM_CH-1:0]          stall_mask;
  logic                       process_done;
  logic                       update_hold;
  logic [NUM_CH-1:0]          ch_ready;
  logic [CH_W-1:0]            cur_ch;
  logic [SET_BITS-1:0]        cur_set;
  logic                       rd_set_en;
  logic                       rd_mem_en;
  logic                       lookup_en;
  logic                       process_en;
  logic                       update_en;
  logic                       idle;
  logic [2:0]                 state_dbg;

  modport master (
    output ch_valid, ch_set, stall_mask, process_done, update_hold,
    input  ch_ready, cur_ch, cur_set, rd_set_en, rd_mem_en, lookup_en,
           process_en, update_en, idle, state_dbg
  );

  modport slave (
    input  ch_valid, ch_set, stall_mask, process_done, update_hold,
    output ch_ready, cur_ch, cur_set, rd_set_en, rd_mem_en, lookup_en,
           process_en, update_en, idle, state_dbg
  );
endinterface

// File: rtl/llc_chan_sched.sv
// LLC front-end scheduler: fixed-priority channel arbitration plus the set-read/mem-read/lookup/process/update sequencer.
// Optional starvation aging is enabled by defining LLC_SCHED_AGING_EN.
module llc_chan_sched #(
  parameter int NUM_CH   = 4,
  parameter int SET_BITS = 9,
  parameter int RD_LAT   = 2,
  parameter int AGE_MAX  = 7
) (
  input  logic             clk,
  input  logic             rst,
  llc_chan_sched_if.slave  bus
);
  localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 2 || NUM_CH > 8 || RD_LAT < 1 || RD_LAT > 7 || AGE_MAX < 1) begin : g_bad_cfg
    $error("llc_chan_sched: parameter out of range");
  end

  typedef enum logic [2:0] {
    DECODE   = 3'd0,
    READ_SET = 3'd1,
    READ_MEM = 3'd2,
    LOOKUP   = 3'd3,
    PROCESS  = 3'd4,
    UPDATE   = 3'd5
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          lat_cnt;
  logic [CH_W-1:0]     cur_ch_q;
  logic [SET_BITS-1:0] cur_set_q;
  logic                rd_set_q, rd_mem_q, lookup_q, process_q, update_q;
  logic [NUM_CH-1:0]   elig;
  logic [NUM_CH-1:0]   starved;
  logic [CH_W-1:0]     winner;
  logic                any_elig;
  logic                grant;

  assign elig = bus.ch_valid & ~bus.stall_mask;

`ifdef LLC_SCHED_AGING_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);
  logic [AGE_W-1:0] age [NUM_CH];

  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_CH; i++)
      starved[i] = elig[i] && (age[i] == AGE_W'(AGE_MAX));
  end

  // Losers that were eligible at the grant age; the winner restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) age[i] <= '0;
    end else if (grant) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (CH_W'(i) == winner)
          age[i] <= '0;
        else if (elig[i] && age[i] != AGE_W'(AGE_MAX))
          age[i] <= age[i] + 1'b1;
      end
    end
  end
`else
  assign starved = '0;
`endif

  // Lowest starved channel overrides plain lowest-index priority.
  always_comb begin
    winner   = '0;
    any_elig = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        winner   = CH_W'(i);
        any_elig = 1'b1;
      end
    end
    if (|starved) begin
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (starved[i]) winner = CH_W'(i);
    end
  end

  assign grant        = any_elig && (state == DECODE) && !rst;
  assign bus.ch_ready = grant ? (NUM_CH'(1) << winner) : '0;
  assign bus.idle     = (state == DECODE) && !grant;

  always_comb begin
    state_nxt = state;
    case (state)
      DECODE:   if (grant) state_nxt = READ_SET;
      READ_SET: state_nxt = READ_MEM;
      READ_MEM: if (lat_cnt == 3'd0) state_nxt = LOOKUP;
      LOOKUP:   state_nxt = PROCESS;
      PROCESS:  if (bus.process_done) state_nxt = UPDATE;
      UPDATE:   if (!bus.update_hold) state_nxt = DECODE;
      default:  state_nxt = DECODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DECODE;
      lat_cnt   <= 3'd0;
      cur_ch_q  <= '0;
      cur_set_q <= '0;
      rd_set_q  <= 1'b0;
      rd_mem_q  <= 1'b0;
      lookup_q  <= 1'b0;
      process_q <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_set_q  <= (state_nxt == READ_SET);
      rd_mem_q  <= (state_nxt == READ_MEM);
      lookup_q  <= (state_nxt == LOOKUP);
      process_q <= (state_nxt == LOOKUP) || (state_nxt == PROCESS);
      update_q  <= (state_nxt == UPDATE);
      // Counter is loaded on the READ_SET -> READ_MEM edge so READ_MEM lasts RD_LAT cycles.
      if (state == READ_SET)
        lat_cnt <= 3'(RD_LAT - 1);
      else if (state == READ_MEM && lat_cnt != 3'd0)
        lat_cnt <= lat_cnt - 3'd1;
      if (grant) begin
        cur_ch_q  <= winner;
        cur_set_q <= bus.ch_set[int'(winner) * SET_BITS +: SET_BITS];
      end
    end
  end

  assign bus.cur_ch     = cur_ch_q;
  assign bus.cur_set    = cur_set_q;
  assign bus.rd_set_en  = rd_set_q;
  assign bus.rd_mem_en  = rd_mem_q;
  assign bus.lookup_en  = lookup_q;
  assign bus.process_en = process_q;
  assign bus.update_en  = update_q;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_llc_chan_sched.sv
// Testbench for llc_chan_sched: transaction-timeline reference model feeds a per-cycle expected queue; a monitor compares at negedge.
module tb_llc_chan_sched;
  localparam int NUM_CH   = 4;
  localparam int SET_BITS = 9;
  localparam int RD_LAT   = 3;
  localparam int AGE_MAX  = 2;
  localparam int CW       = 2;
  localparam int W        = NUM_CH + 1 + 5 + CW + SET_BITS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  llc_chan_sched_if #(.NUM_CH(NUM_CH), .SET_BITS(SET_BITS)) bus ();

  llc_chan_sched #(
    .NUM_CH(NUM_CH), .SET_BITS(SET_BITS), .RD_LAT(RD_LAT), .AGE_MAX(AGE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // ---------------- reference model ----------------
  logic [NUM_CH-1:0]   req_v;
  logic [SET_BITS-1:0] req_set [NUM_CH];
  bit                  keep_valid;
  bit                  m_busy;
  bit                  m_upd;
  int                  m_t;
  int                  m_ch;
  logic [SET_BITS-1:0] m_set;
  int                  grants;
`ifdef LLC_SCHED_AGING_EN
  int                  age [NUM_CH];
`endif

  // Phase as a function of time since the grant: 0 idle, 1 set read, 2 mem read, 3 lookup, 4 process, 5 update.
  function automatic int phase();
    if (!m_busy)              return 0;
    if (m_upd)                return 5;
    if (m_t == 1)             return 1;
    if (m_t <= RD_LAT + 1)    return 2;
    if (m_t == RD_LAT + 2)    return 3;
    return 4;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_upd = 0; m_t = 0; m_ch = 0; m_set = '0;
`ifdef LLC_SCHED_AGING_EN
    for (int i = 0; i < NUM_CH; i++) age[i] = 0;
`endif
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic pd, input logic hold,
                      input logic [NUM_CH-1:0] stall, input int p_req);
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] rdy;
    logic [4:0]        en;
    logic [CW-1:0]     ch_bits;
    int                win;
    int                ph;
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!req_v[i] && p_req > 0 && $urandom_range(0, 99) < p_req) begin
        req_v[i]   = 1'b1;
        req_set[i] = SET_BITS'($urandom_range(0, (1 << SET_BITS) - 1));
      end
    end
    rst              = r;
    bus.process_done = pd;
    bus.update_hold  = hold;
    bus.stall_mask   = stall;
    bus.ch_valid     = req_v;
    for (int i = 0; i < NUM_CH; i++) bus.ch_set[i*SET_BITS +: SET_BITS] = req_set[i];

    elig = req_v & ~stall;
    win  = -1;
`ifdef LLC_SCHED_AGING_EN
    for (int i = 0; i < NUM_CH; i++) if (win < 0 && elig[i] && age[i] == AGE_MAX) win = i;
`endif
    for (int i = 0; i < NUM_CH; i++) if (win < 0 && elig[i]) win = i;
    ph  = phase();
    rdy = (ph == 0 && !r && win >= 0) ? (NUM_CH'(1) << win) : '0;
    en  = {ph == 1, ph == 2, ph == 3, ph == 3 || ph == 4, ph == 5};
    ch_bits = CW'(m_ch);
    exp_q.push_back({rdy, (ph == 0) && (rdy == '0), en, ch_bits, m_set});

    // Advance the model across the coming edge.
    if (r) begin
      model_reset();
    end else if (!m_busy) begin
      if (win >= 0) begin
        grants++;
        m_busy = 1; m_upd = 0; m_t = 1; m_ch = win; m_set = req_set[win];
`ifdef LLC_SCHED_AGING_EN
        for (int i = 0; i < NUM_CH; i++) begin
          if (i == win) age[i] = 0;
          else if (elig[i] && age[i] < AGE_MAX) age[i]++;
        end
`endif
        if (!keep_valid) req_v[win] = 1'b0;
      end
    end else if (m_upd) begin
      if (!hold) m_busy = 0;
    end else if (ph == 4 && pd) begin
      m_upd = 1;
    end else begin
      m_t++;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act = {bus.ch_ready, bus.idle, bus.rd_set_en, bus.rd_mem_en, bus.lookup_en,
             bus.process_en, bus.update_en, bus.cur_ch, bus.cur_set};
      checks++;
      if (act !== exp_v) begin
        failures++;
        $display("FAIL outputs cyc=%0d {rdy,idle,en[5],ch,set} actual=%b_%b_%b_%0d_%0d required=%b_%b_%b_%0d_%0d",
                 cyc, act[W-1 -: NUM_CH], act[W-NUM_CH], act[W-NUM_CH-1 -: 5],
                 act[SET_BITS +: CW], act[SET_BITS-1:0],
                 exp_v[W-1 -: NUM_CH], exp_v[W-NUM_CH], exp_v[W-NUM_CH-1 -: 5],
                 exp_v[SET_BITS +: CW], exp_v[SET_BITS-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int ph;
    int pcnt;
    int hcnt;
    int wait_cnt;
    rst = 1'b1;
    bus.ch_valid = '0; bus.ch_set = '0; bus.stall_mask = '0;
    bus.process_done = 1'b0; bus.update_hold = 1'b0;
    req_v = '0; keep_valid = 0; grants = 0;
    for (int i = 0; i < NUM_CH; i++) req_set[i] = '0;
    model_reset();
    repeat (3) @(posedge clk);

    // Reset state, then 1010 -> channel 1 granted first.
    step(1, 0, 0, '0, 0);
    @(negedge clk);
    checks++;
    if (bus.state_dbg !== 3'd0 || bus.cur_ch !== '0 || bus.cur_set !== '0 ||
        {bus.rd_set_en, bus.rd_mem_en, bus.lookup_en, bus.process_en, bus.update_en} !== 5'b0) begin
      failures++;
      $display("FAIL reset state: state=%0d cur_ch=%0d cur_set=%0d en=%b required state=0 cur_ch=0 cur_set=0 en=00000",
               bus.state_dbg, bus.cur_ch, bus.cur_set,
               {bus.rd_set_en, bus.rd_mem_en, bus.lookup_en, bus.process_en, bus.update_en});
    end
    checks++;
    if (bus.ch_ready !== '0) begin
      failures++;
      $display("FAIL reset ch_ready: actual=%b required=0", bus.ch_ready);
    end
    req_v = 4'b1010;
    req_set[1] = SET_BITS'($urandom_range(0, 511));
    req_set[3] = SET_BITS'($urandom_range(0, 511));
    repeat (20) step(0, 1, 0, '0, 0);

    // Single request, process_done high: minimum-length transaction.
    req_v = 4'b0001; req_set[0] = 9'h155;
    repeat (12) step(0, 1, 0, '0, 0);

    // process_done pulsed in LOOKUP only, then raised on the 5th PROCESS cycle.
    req_v = 4'b0100; req_set[2] = 9'h0a3; pcnt = 0;
    repeat (16) begin
      ph = phase();
      step(0, (ph == 3) || (ph == 4 && pcnt >= 4), 0, '0, 0);
      if (ph == 4) pcnt++;
    end

    // update_hold for 6 UPDATE cycles while channel 0 waits.
    req_v = 4'b0100; req_set[2] = 9'h1f0; hcnt = 0;
    repeat (22) begin
      ph = phase();
      if (ph == 4) begin req_v[0] = 1'b1; req_set[0] = 9'h021; end
      step(0, 1, (ph == 5 && hcnt < 6), '0, 0);
      if (ph == 5) hcnt++;
    end

    // Stall mask steers the grant to channel 1; reset lands in PROCESS.
    req_v = 4'b0011; req_set[0] = 9'h0ff; req_set[1] = 9'h100;
    repeat (8) step(0, 0, 0, 4'b0001, 0);
    step(1, 0, 0, 4'b0001, 0);
    repeat (3) step(0, 0, 0, 4'b1111, 0);
    req_v = '0;
    repeat (12) step(0, 1, 0, '0, 0);

    // Channels 0 and 3 continuously valid (aging pattern when enabled).
    keep_valid = 1; req_v = 4'b1001; req_set[0] = 9'h011; req_set[3] = 9'h033;
    repeat (60) step(0, 1, 0, '0, 0);
    keep_valid = 0; req_v = '0;
    repeat (10) step(0, 1, 0, '0, 0);

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0), NUM_CH'($urandom_range(0, 15) & $urandom_range(0, 15)), 30);
    end

    // Drain: quiet inputs, bounded wait for idle.
    @(negedge clk); #1;
    rst = 1'b0;
    bus.ch_valid = '0; bus.stall_mask = '0;
    bus.process_done = 1'b1; bus.update_hold = 1'b0;
    wait_cnt = 0;
    while (!bus.idle && wait_cnt < 40) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    checks++;
    if (bus.idle !== 1'b1) begin
      failures++;
      $display("FAIL drain wait expired after %0d cycles: idle=%b state=%0d", wait_cnt, bus.idle, bus.state_dbg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
